counter_slot_arbiter: RTL
=========================

COUNTER_SLOT_ARBITER -- requirements
Module: counter_slot_arbiter

Interface
REQ-001 Parameter EXPONENT, default 4: slot length is 2^EXPONENT clock cycles; legal range 1..16.
REQ-002 Parameter REQUESTERS, default 4: number of requesters; legal range 2..16.
REQ-003 Derived width IDX_W = max(1, ceil(log2(REQUESTERS))).
REQ-004 i_CLOCK_POS  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 i_RESET_POS  input  1  asynchronous reset, active-high.
REQ-006 i_VECTOR_REQUEST  input  REQUESTERS  per-requester request level; bit k high means requester k wants the resource.
REQ-007 i_BIT_DONE  input  1  current owner releases before the slot ends; ignored unless the state is GRANT.
REQ-008 o_VECTOR_GRANT  output  REQUESTERS  one-hot grant, registered; all-zero when no owner.
REQ-009 o_VECTOR_OWNER  output  IDX_W  index of the current or most recent owner, registered.
REQ-010 o_VECTOR_SLOT  output  EXPONENT  cycles elapsed in the current slot (up-count), registered.
REQ-011 o_BIT_BUSY  output  1  high exactly while the state is GRANT.
REQ-012 o_BIT_EXPIRE  output  1  one-cycle pulse when a slot ends by terminal count.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT and GUARD.
REQ-014 IDLE: if any request bit is high, the next state SHALL be GRANT with the round-robin winner granted; otherwise the FSM SHALL stay in IDLE.
REQ-015 Grant latency SHALL be one cycle: a request first sampled high at edge t in IDLE gives o_VECTOR_GRANT one-hot from edge t onward, visible in cycle t+1.
REQ-016 Round-robin SHALL search from index (o_VECTOR_OWNER+1) mod REQUESTERS upward with wrap; the first high request bit wins.
REQ-017 On entry to GRANT, o_VECTOR_SLOT SHALL load 0 and o_VECTOR_OWNER SHALL load the winner index.
REQ-018 In GRANT, o_VECTOR_SLOT SHALL increment by 1 per cycle, modulo 2^EXPONENT.
REQ-019 GRANT SHALL end on the first of these events, going to GUARD: terminal count (o_VECTOR_SLOT = 2^EXPONENT-1), i_BIT_DONE high, or the owner's request bit low.
REQ-020 On a terminal-count exit, o_BIT_EXPIRE SHALL be high for exactly the cycle following the exit edge (the first GUARD cycle); on any other exit it SHALL stay low.
REQ-021 If terminal count coincides with i_BIT_DONE or a request drop, the block SHALL perform one release and SHALL still pulse o_BIT_EXPIRE.
REQ-022 GUARD SHALL last exactly one cycle with o_VECTOR_GRANT all-zero and o_BIT_BUSY low, and o_VECTOR_SLOT SHALL hold at 0.
REQ-023 Leaving GUARD: if any request is high, the next state SHALL be GRANT (arbitration per REQ-016); otherwise it SHALL be IDLE.
REQ-024 The same requester SHALL be re-granted after GUARD only if no other request bit is high.
REQ-025 Request bits of non-owners SHALL NOT affect an active GRANT.
REQ-026 In IDLE and GUARD, o_VECTOR_OWNER SHALL hold its last value.
REQ-027 o_VECTOR_GRANT SHALL never have more than one bit set.
REQ-028 o_VECTOR_GRANT SHALL equal the one-hot decode of o_VECTOR_OWNER whenever o_BIT_BUSY is high.

Reset
REQ-029 While i_RESET_POS is high, without waiting for a clock edge: state = IDLE, o_VECTOR_GRANT = 0, o_VECTOR_OWNER = REQUESTERS-1, o_VECTOR_SLOT = 0, o_BIT_BUSY = 0, o_BIT_EXPIRE = 0.
REQ-030 Reset asserted during GRANT SHALL drop the grant immediately and SHALL NOT produce an expire pulse.
REQ-031 After reset deassertion, requester 0 SHALL have the highest priority for the first arbitration.

Verification (EXPONENT=2, REQUESTERS=4)
REQ-032 Reset, then REQUEST=4'b1111 held -> grants in the order 0001, 0010, 0100, 1000, 0001; each grant lasts 4 cycles with SLOT 0,1,2,3; one GUARD cycle between grants; EXPIRE pulses once per slot.
REQ-033 REQUEST=4'b0100 only; i_BIT_DONE pulsed at SLOT=1 -> GRANT=0100 for 2 cycles, then GUARD with EXPIRE=0; GRANT=0100 again the next cycle.
REQ-034 Owner 1 drops its request at SLOT=2 while REQUEST[3] is high -> GUARD for 1 cycle, then GRANT=1000 with OWNER=3.
REQ-035 i_BIT_DONE high at SLOT=3 -> exactly one GUARD cycle and EXPIRE=1 for that cycle.
REQ-036 i_RESET_POS asserted mid-edge at SLOT=2 -> GRANT=0, BUSY=0 and SLOT=0 immediately; OWNER=3; the next grant goes to the lowest-index requester.
REQ-037 Every run: assertions on REQ-027 (one-hot grant), REQ-028 (grant matches owner), and o_BIT_BUSY equal to the OR of o_VECTOR_GRANT.

Source files
------------

// File: rtl/counter_slot_arbiter.sv
// Round-robin arbiter that hands a shared resource out in fixed-length time slots,
// with an early release on done or request drop and one idle guard cycle between owners.
module counter_slot_arbiter #(
  parameter  int EXPONENT   = 4,
  parameter  int REQUESTERS = 4,
  localparam int IDX_W      = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
) (
  input  logic                  i_CLOCK_POS,
  input  logic                  i_RESET_POS,
  input  logic [REQUESTERS-1:0] i_VECTOR_REQUEST,
  input  logic                  i_BIT_DONE,
  output logic [REQUESTERS-1:0] o_VECTOR_GRANT,
  output logic [IDX_W-1:0]      o_VECTOR_OWNER,
  output logic [EXPONENT-1:0]   o_VECTOR_SLOT,
  output logic                  o_BIT_BUSY,
  output logic                  o_BIT_EXPIRE
);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t                  state_q, state_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [EXPONENT-1:0]     slot_q, slot_d;
  logic                    expire_q, expire_d;

  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  logic [IDX_W-1:0]        cand;
  logic [REQUESTERS-1:0]   win_onehot;
  logic                    terminal;
  logic                    owner_req;

  // Search starts just above the last owner, so reset value REQUESTERS-1 favours requester 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      cand = IDX_W'((int'(owner_q) + 1 + i) % REQUESTERS);
      if (!win_found && i_VECTOR_REQUEST[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_decode
      assign win_onehot[gi] = win_found && (win_idx == IDX_W'(gi));
    end
  endgenerate

  assign terminal  = &slot_q;
  assign owner_req = i_VECTOR_REQUEST[owner_q];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    slot_d   = slot_q;
    expire_d = 1'b0;
    unique case (state_q)
      IDLE, GUARD: begin
        grant_d = '0;
        slot_d  = '0;
        if (win_found) begin
          state_d = GRANT;
          grant_d = win_onehot;
          owner_d = win_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        // Only the owner's own request matters here; a coincident done/drop still counts as expiry.
        if (terminal || i_BIT_DONE || !owner_req) begin
          state_d  = GUARD;
          grant_d  = '0;
          slot_d   = '0;
          expire_d = terminal;
        end else begin
          slot_d = slot_q + EXPONENT'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        slot_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
    if (i_RESET_POS) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= IDX_W'(REQUESTERS - 1);
      slot_q   <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      slot_q   <= slot_d;
      expire_q <= expire_d;
    end
  end

  assign o_VECTOR_GRANT = grant_q;
  assign o_VECTOR_OWNER = owner_q;
  assign o_VECTOR_SLOT  = slot_q;
  assign o_BIT_BUSY     = (state_q == GRANT);
  assign o_BIT_EXPIRE   = expire_q;

endmodule
